// File: rtl/instr_fetch_decode_if.sv
// Bus bundle between the fetch/decode front end, instruction memory and execute.
// master = fetch/decode side, slave = memory/execute side.
interface instr_fetch_decode_if #(
  parameter int ADDR_W = 8
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [7:0]        imem_rdata;
  logic              issue_valid;
  logic              issue_ready;
  logic [2:0]        opcode;
  logic [1:0]        rd;
  logic [1:0]        rs;
  logic              imm_valid;
  logic [7:0]        imm;

  modport master (
    output imem_req, imem_addr, issue_valid, opcode, rd, rs, imm_valid, imm,
    input  imem_ack, imem_rdata, issue_ready
  );

  modport slave (
    input  imem_req, imem_addr, issue_valid, opcode, rd, rs, imm_valid, imm,
    output imem_ack, imem_rdata, issue_ready
  );
endinterface

// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode front end for the 8-bit CPU.
// Fetches one instruction word (plus an optional immediate byte), decodes the
// fields and holds them for the execute stage until the issue handshake.
// Optional feature: define IFD_INSTR_COUNT_EN to add a saturating 16-bit
// issued-instruction counter on output instr_count.
module instr_fetch_decode #(
  parameter int              ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 pc_load,
  input  logic [ADDR_W-1:0]    pc_load_addr,
  instr_fetch_decode_if.master bus,
  output logic                 busy
`ifdef IFD_INSTR_COUNT_EN
  ,
  output logic [15:0]          instr_count
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    FETCH_IMM = 2'd2,
    ISSUE     = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc;
  logic [2:0]        opcode_q;
  logic [1:0]        rd_q;
  logic [1:0]        rs_q;
  logic              imm_valid_q;
  logic [7:0]        imm_q;
  logic              fetching;
  logic              fire;

  assign fetching = (state == FETCH) || (state == FETCH_IMM);
  assign fire     = (state == ISSUE) && bus.issue_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; a redirect during fetch restarts fetching at the new pc
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (run) state_next = FETCH;
      FETCH: begin
        if (pc_load)           state_next = FETCH;
        else if (bus.imem_ack) state_next = bus.imem_rdata[0] ? FETCH_IMM : ISSUE;
      end
      FETCH_IMM: begin
        if (pc_load)           state_next = FETCH;
        else if (bus.imem_ack) state_next = ISSUE;
      end
      ISSUE:     if (fire) state_next = run ? FETCH : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Program counter: redirect beats the post-fetch increment in every state
  always_ff @(posedge clk) begin
    if (rst)                          pc <= RESET_PC;
    else if (pc_load)                 pc <= pc_load_addr;
    else if (fetching && bus.imem_ack) pc <= pc + ADDR_W'(1);
  end

  // Decoded fields; an ack coinciding with a redirect is discarded
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q    <= '0;
      rd_q        <= '0;
      rs_q        <= '0;
      imm_valid_q <= 1'b0;
      imm_q       <= '0;
    end else if (!pc_load && bus.imem_ack) begin
      if (state == FETCH) begin
        opcode_q    <= bus.imem_rdata[7:5];
        rd_q        <= bus.imem_rdata[4:3];
        rs_q        <= bus.imem_rdata[2:1];
        imm_valid_q <= bus.imem_rdata[0];
        imm_q       <= '0;
      end else if (state == FETCH_IMM) begin
        imm_q       <= bus.imem_rdata;
      end
    end
  end

  assign bus.imem_req    = fetching;
  assign bus.imem_addr   = pc;
  assign bus.issue_valid = (state == ISSUE);
  assign bus.opcode      = opcode_q;
  assign bus.rd          = rd_q;
  assign bus.rs          = rs_q;
  assign bus.imm_valid   = imm_valid_q;
  assign bus.imm         = imm_q;
  assign busy            = (state != IDLE);

`ifdef IFD_INSTR_COUNT_EN
  logic [15:0] count_q;

  // Issued-instruction counter, saturating at all ones
  always_ff @(posedge clk) begin
    if (rst)                        count_q <= '0;
    else if (fire && count_q != '1) count_q <= count_q + 16'd1;
  end

  assign instr_count = count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed testbench for instr_fetch_decode with a simple instruction memory model.
module tb_instr_fetch_decode;

  logic       clk;
  logic       rst;
  logic       run;
  logic       pc_load;
  logic [7:0] pc_load_addr;
  logic       busy;
`ifdef IFD_INSTR_COUNT_EN
  logic [15:0] instr_count;
`endif

  logic [7:0] mem [256];
  int unsigned n_cmp;
  int unsigned n_bad;

  instr_fetch_decode_if #(.ADDR_W(8)) bus ();

  instr_fetch_decode #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .bus          (bus),
    .busy         (busy)
`ifdef IFD_INSTR_COUNT_EN
    ,
    .instr_count  (instr_count)
`endif
  );

  assign bus.imem_rdata = mem[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'b010_10_01_0;
    mem[8'h01] = 8'b000_01_11_1;
    mem[8'h02] = 8'hA5;
    mem[8'hFF] = 8'b101_11_00_0;
    mem[8'h40] = 8'b011_00_10_1;
    mem[8'h41] = 8'h3C;

    rst = 1'b1; run = 1'b0; pc_load = 1'b0; pc_load_addr = 8'h00;
    bus.imem_ack = 1'b1; bus.issue_ready = 1'b0;
    step(); step();

    // reset state
    check("rst_busy",  busy, 0);
    check("rst_addr",  bus.imem_addr, 8'h00);
    check("rst_req",   bus.imem_req, 0);
    check("rst_valid", bus.issue_valid, 0);
    check("rst_op",    bus.opcode, 0);
    check("rst_imm",   bus.imm, 0);

    // plain instruction at 0
    rst = 1'b0; run = 1'b1;
    step();
    check("t1_req",   bus.imem_req, 1);
    check("t1_addr",  bus.imem_addr, 8'h00);
    check("t1_valid0", bus.issue_valid, 0);
    step();
    check("t1_valid", bus.issue_valid, 1);
    check("t1_op",    bus.opcode, 3'b010);
    check("t1_rd",    bus.rd, 2);
    check("t1_rs",    bus.rs, 1);
    check("t1_immv",  bus.imm_valid, 0);
    check("t1_imm",   bus.imm, 0);
    check("t1_pc",    bus.imem_addr, 8'h01);

    // execute stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_valid", bus.issue_valid, 1);
      check("t3_op",    bus.opcode, 3'b010);
      check("t3_rd",    bus.rd, 2);
      check("t3_req",   bus.imem_req, 0);
    end
    bus.issue_ready = 1'b1;
    step();
    check("t3_refetch_req",  bus.imem_req, 1);
    check("t3_refetch_addr", bus.imem_addr, 8'h01);
    check("t3_valid_drop",   bus.issue_valid, 0);

    // instruction with immediate at 1/2
    step();
    check("t2_imm_req",   bus.imem_req, 1);
    check("t2_imm_addr",  bus.imem_addr, 8'h02);
    check("t2_valid0",    bus.issue_valid, 0);
    step();
    check("t2_valid", bus.issue_valid, 1);
    check("t2_op",    bus.opcode, 0);
    check("t2_rd",    bus.rd, 1);
    check("t2_rs",    bus.rs, 3);
    check("t2_immv",  bus.imm_valid, 1);
    check("t2_imm",   bus.imm, 8'hA5);
    check("t2_pc",    bus.imem_addr, 8'h03);

    // redirect during issue to 0xFF; pending issue still completes
    pc_load = 1'b1; pc_load_addr = 8'hFF;
    step();
    pc_load = 1'b0;
    check("t4_addr",  bus.imem_addr, 8'hFF);
    check("t4_req",   bus.imem_req, 1);
    check("t4_valid0", bus.issue_valid, 0);
    step();
    check("t4_valid", bus.issue_valid, 1);
    check("t4_op",    bus.opcode, 3'b101);
    check("t4_rd",    bus.rd, 3);
    check("t4_rs",    bus.rs, 0);
    check("t4_wrap",  bus.imem_addr, 8'h00);
    step();
    check("t4_next_addr", bus.imem_addr, 8'h00);
    check("t4_next_req",  bus.imem_req, 1);

    // redirect coincides with fetch ack: word dropped
    pc_load = 1'b1; pc_load_addr = 8'h40;
    step();
    pc_load = 1'b0;
    check("t5_valid", bus.issue_valid, 0);
    check("t5_addr",  bus.imem_addr, 8'h40);
    check("t5_req",   bus.imem_req, 1);
    check("t5_op_kept", bus.opcode, 3'b101);

    // run dropped during the immediate fetch
    step();
    check("t6_imm_addr", bus.imem_addr, 8'h41);
    check("t6_imm_req",  bus.imem_req, 1);
    run = 1'b0;
    step();
    check("t6_valid", bus.issue_valid, 1);
    check("t6_op",    bus.opcode, 3'b011);
    check("t6_rd",    bus.rd, 0);
    check("t6_rs",    bus.rs, 2);
    check("t6_immv",  bus.imm_valid, 1);
    check("t6_imm",   bus.imm, 8'h3C);
    check("t6_busy",  busy, 1);
    step();
    check("t6_idle_busy",  busy, 0);
    check("t6_idle_valid", bus.issue_valid, 0);
    check("t6_idle_req",   bus.imem_req, 0);
    check("t6_idle_addr",  bus.imem_addr, 8'h42);
`ifdef IFD_INSTR_COUNT_EN
    check("cnt", instr_count, 16'd4);
`endif

    // memory stall: address held until ack
    bus.imem_ack = 1'b0; run = 1'b1;
    step();
    check("stall_req",  bus.imem_req, 1);
    check("stall_addr", bus.imem_addr, 8'h42);
    step();
    check("stall_hold_addr", bus.imem_addr, 8'h42);
    check("stall_valid",     bus.issue_valid, 0);

    // reset beats a simultaneous redirect
    rst = 1'b1; pc_load = 1'b1; pc_load_addr = 8'h77;
    step();
    check("rst2_busy", busy, 0);
    check("rst2_addr", bus.imem_addr, 8'h00);
    check("rst2_req",  bus.imem_req, 0);
`ifdef IFD_INSTR_COUNT_EN
    check("rst2_cnt", instr_count, 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
